// File: rtl/map_control_unit.sv
// map_control_unit: boot/run/halt sequencer and instruction decoder for the MAP core datapath
// Ports: CLK/RST_N clock and async active-low reset; RESUME leaves HALT;
//        Ins/ZeroFlag/E instruction word and ALU flags; SEL_MUX1/4/5, OPMode_Main,
//        WR, Stack_Mode datapath controls; HALTED, TRAP, RETIRED status.
// Optional: define MAP_TRAP_ON_E_EN to trap ALU instructions that raise E.
module map_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             RESUME,
    input  logic [7:0]       Ins,
    input  logic             ZeroFlag,
    input  logic             E,
    output logic [1:0]       SEL_MUX1,
    output logic [1:0]       SEL_MUX4,
    output logic [1:0]       SEL_MUX5,
    output logic [4:0]       OPMode_Main,
    output logic [1:0]       WR,
    output logic [1:0]       Stack_Mode,
    output logic             HALTED,
    output logic             TRAP,
    output logic [CNT_W-1:0] RETIRED
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t state;
    logic   trap_now;
    logic   trap_q;
`ifdef MAP_TRAP_ON_E_EN
    assign trap_now = state == RUN && Ins[7:6] == 2'b00 && E;
`else
    logic unused_e;
    assign unused_e = E;
    assign trap_now = 1'b0;
`endif
    assign TRAP   = trap_q;
    assign HALTED = state == HALT;
    // While RST_N is low the state is already BOOT, so the boot controls appear with no extra term.
    always_comb begin
        SEL_MUX1    = 2'd0;
        SEL_MUX4    = 2'd0;
        SEL_MUX5    = 2'd0;
        OPMode_Main = 5'd0;
        WR          = 2'b00;
        Stack_Mode  = 2'b00;
        if (state == BOOT) begin
            SEL_MUX4   = 2'd3;
            SEL_MUX5   = 2'd1;
            Stack_Mode = 2'b11;
        end else if (state == HALT) begin
            SEL_MUX4 = RESUME ? 2'd0 : 2'd1;
        end else begin
            case (Ins[7:6])
                2'b00: begin
                    OPMode_Main = Ins[5:1];
                    WR[0]       = !trap_now;
                    SEL_MUX4    = trap_now ? 2'd3 : 2'd0;
                end
                2'b01: begin
                    SEL_MUX1 = 2'd2;
                    WR[0]    = 1'b1;
                end
                2'b10: SEL_MUX4 = (!Ins[0] || ZeroFlag) ? 2'd1 : 2'd0;
                default: begin
                    if (!Ins[5]) begin
                        SEL_MUX1 = 2'd3;
                        WR[0]    = 1'b1;
                    end else if (Ins[4]) begin
                        WR[1] = 1'b1;
                    end else begin
                        Stack_Mode = Ins[3:2] == 2'b00 ? 2'b01 : Ins[3:2] == 2'b01 ? 2'b10 : 2'b00;
                        SEL_MUX1   = Ins[3:2] == 2'b01 ? 2'd1 : 2'd0;
                        WR[0]      = Ins[3:2] == 2'b01;
                        SEL_MUX4   = Ins[3:2] == 2'b10 ? 2'd2 : 2'd0;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= BOOT;
            trap_q  <= 1'b0;
            RETIRED <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (Ins == 8'h80) state <= HALT;
                    if (!trap_now) RETIRED <= RETIRED + CNT_W'(1);
                    trap_q <= trap_q | trap_now;
                end
                default: if (RESUME) state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_map_control_unit.sv
// tb_map_control_unit: directed scoreboard bench for map_control_unit
module tb_map_control_unit;
    logic        CLK = 0;
    logic        RST_N = 0;
    logic        RESUME = 0;
    logic [7:0]  Ins = 8'h00;
    logic        ZeroFlag = 0;
    logic        E = 0;
    logic [1:0]  SEL_MUX1, SEL_MUX4, SEL_MUX5, WR, Stack_Mode;
    logic [4:0]  OPMode_Main;
    logic        HALTED, TRAP;
    logic [15:0] RETIRED;
    map_control_unit #(.CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .RESUME(RESUME), .Ins(Ins), .ZeroFlag(ZeroFlag), .E(E),
        .SEL_MUX1(SEL_MUX1), .SEL_MUX4(SEL_MUX4), .SEL_MUX5(SEL_MUX5), .OPMode_Main(OPMode_Main),
        .WR(WR), .Stack_Mode(Stack_Mode), .HALTED(HALTED), .TRAP(TRAP), .RETIRED(RETIRED)
    );
    always #5 CLK = ~CLK;
    typedef struct {
        logic [32:0] v;
        string       nm;
    } exp_t;
    exp_t        q[$];
    logic        chk = 0;
    int          ncmp = 0;
    int          nfail = 0;
    logic [15:0] r_exp = 0;
    logic        t_exp = 0;
    logic [32:0] act;
    assign act = {SEL_MUX1, SEL_MUX4, SEL_MUX5, OPMode_Main, WR, Stack_Mode, HALTED, TRAP, RETIRED};
    function automatic logic [32:0] pk(input logic [1:0] m1, m4, m5, input logic [4:0] op,
                                       input logic [1:0] wr, sm, input logic h, t, input logic [15:0] r);
        return {m1, m4, m5, op, wr, sm, h, t, r};
    endfunction
    task automatic push(input logic [32:0] v, input string nm);
        exp_t it;
        it.v  = v;
        it.nm = nm;
        q.push_back(it);
        chk = 1;
    endtask
    // Monitor: one expected entry per strobed cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (chk) begin
            ncmp++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL underflow: output strobed with no expected entry");
            end else begin
                exp_t it;
                it = q.pop_front();
                if (act !== it.v) begin
                    nfail++;
                    $display("FAIL %s: got m1=%0d m4=%0d m5=%0d op=%0d wr=%b sm=%b h=%b t=%b r=%0d, want %h (act %h)",
                             it.nm, act[32:31], act[30:29], act[28:27], act[26:22], act[21:20], act[19:18],
                             act[17], act[16], act[15:0], it.v, act);
                end
            end
        end
    end
    // One RUN/HALT cycle: drive inputs, push expectation, then advance the retire model.
    task automatic step(input logic [7:0] ins, input logic zf, ev, res,
                        input logic [1:0] m1, m4, wr, sm, input logic [4:0] op,
                        input logic h, inc, input string nm);
        @(posedge CLK);
        #1;
        Ins = ins; ZeroFlag = zf; E = ev; RESUME = res;
        push(pk(m1, m4, 2'd0, op, wr, sm, h, t_exp, r_exp), nm);
        if (inc) r_exp = r_exp + 16'd1;
    endtask
    initial begin
        repeat (3) @(posedge CLK);
        #1;
        push(pk(0, 3, 1, 0, 2'b00, 2'b11, 0, 0, 0), "reset_low");
        @(posedge CLK);
        #1;
        RST_N = 1;
        push(pk(0, 3, 1, 0, 2'b00, 2'b11, 0, 0, 0), "boot");
        step(8'h07, 0, 0, 0, 0, 0, 2'b01, 2'b00, 5'd3, 0, 1, "alu");
        step(8'h8B, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 0, 1, "br_nt");
        step(8'h8B, 1, 0, 0, 0, 1, 2'b00, 2'b00, 5'd0, 0, 1, "br_zf");
        step(8'hE5, 0, 0, 0, 1, 0, 2'b01, 2'b10, 5'd0, 0, 1, "pop");
        step(8'hF2, 0, 0, 0, 0, 0, 2'b10, 2'b00, 5'd0, 0, 1, "st");
        step(8'h43, 0, 0, 0, 2, 0, 2'b01, 2'b00, 5'd0, 0, 1, "ld");
        step(8'hD3, 0, 0, 0, 3, 0, 2'b01, 2'b00, 5'd0, 0, 1, "li");
        step(8'hE0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 5'd0, 0, 1, "push");
        step(8'hE8, 0, 0, 0, 0, 2, 2'b00, 2'b00, 5'd0, 0, 1, "jr");
        step(8'hEC, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 0, 1, "nop");
        step(8'h84, 0, 0, 0, 0, 1, 2'b00, 2'b00, 5'd0, 0, 1, "br_uncond");
        step(8'h80, 0, 0, 0, 0, 1, 2'b00, 2'b00, 5'd0, 0, 1, "halt_ins");
        for (int i = 0; i < 10; i++)
            step(i[0] ? 8'h07 : 8'h80, 0, 0, 0, 0, 1, 2'b00, 2'b00, 5'd0, 1, 0, "halted");
        step(8'h80, 0, 0, 1, 0, 0, 2'b00, 2'b00, 5'd0, 1, 0, "resume");
        step(8'hEC, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 0, 1, "run_again");
        step(8'hEC, 0, 0, 1, 0, 0, 2'b00, 2'b00, 5'd0, 0, 1, "resume_ign");
`ifdef MAP_TRAP_ON_E_EN
        step(8'h07, 0, 1, 0, 0, 3, 2'b00, 2'b00, 5'd3, 0, 0, "alu_trap");
        t_exp = 1;
`else
        step(8'h07, 0, 1, 0, 0, 0, 2'b01, 2'b00, 5'd3, 0, 1, "alu_e_ign");
`endif
        step(8'hEC, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 0, 1, "after_e");
        step(8'h07, 0, 0, 0, 0, 0, 2'b01, 2'b00, 5'd3, 0, 1, "alu_e0");
        @(posedge CLK);
        #1;
        chk = 0;
        Ins = 8'h07;
        #2;
        RST_N = 0;
        push(pk(0, 3, 1, 0, 2'b00, 2'b11, 0, 0, 0), "mid_reset");
        @(posedge CLK);
        #1;
        chk = 0;
        RST_N = 1;
        r_exp = 0;
        t_exp = 0;
        push(pk(0, 3, 1, 0, 2'b00, 2'b11, 0, 0, 0), "boot2");
        step(8'h07, 0, 0, 0, 0, 0, 2'b01, 2'b00, 5'd3, 0, 1, "alu2");
        step(8'hEC, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 0, 1, "ret_after_rst");
        @(posedge CLK);
        #1;
        chk = 0;
        repeat (2) @(posedge CLK);
        ncmp++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL leftover: %0d expected entries never compared, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/map_control_unit.md
Name: map_control_unit

Overview:
- Sequencer for the MAP core datapath.
- Runs a boot sequence after reset, then decodes the 8-bit instruction word each cycle.
- Drives the datapath's mux selects, ALU mode, write enables and stack mode.
- Tracks halt and trap status, and counts retired instructions.
- Sits beside the datapath in the core top level. Consumes Ins/ZeroFlag/E; produces every datapath control input.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
CLK  in  1  core clock, rising edge
RST_N  in  1  asynchronous active-low reset
RESUME  in  1  one-cycle pulse; leaves HALT
Ins  in  8  current instruction word from instruction memory
ZeroFlag  in  1  ALU zero flag
E  in  1  ALU error flag
SEL_MUX1  out  2  RF write source: 0 ALU, 1 stack, 2 heap, 3 immediate Ins[4:1]
SEL_MUX4  out  2  PC source: 0 PC+1, 1 PC+Ins[5:1], 2 RF, 3 PC_BIOS (0)
SEL_MUX5  out  2  SP source: 0 current SP, 1 SP_BIOS (255)
OPMode_Main  out  5  ALU operation
WR  out  2  [0] RF write enable, [1] heap write enable
Stack_Mode  out  2  00 hold, 01 push, 10 pop, 11 load SP from SEL_MUX5 path
HALTED  out  1  high in HALT state
TRAP  out  1  sticky ALU-error trap flag
RETIRED  out  CNT_W  retired-instruction count

Behaviour:
- Reset: RST_N low forces state BOOT, TRAP=0, RETIRED=0, HALTED=0. This applies at any time, including mid-instruction.
- Outputs are combinational from state and Ins. Only the state, TRAP and RETIRED registers are sequential.
- The PC register loads on every clock, so some SEL_MUX4 value is always driven.
- BOOT (one cycle after reset release):
  - SEL_MUX4=3, SEL_MUX5=1, Stack_Mode=11, WR=00, SEL_MUX1=0, OPMode_Main=0.
  - These same values are driven while RST_N is low.
  - Next state: RUN.
- RUN: one instruction per cycle. Defaults are WR=00, Stack_Mode=00, SEL_MUX1=0, SEL_MUX4=0, SEL_MUX5=0, OPMode_Main=0. Decode:
  - Ins[7:6]=00, ALU: OPMode_Main=Ins[5:1], SEL_MUX1=0, WR[0]=1.
  - Ins[7:6]=01, LD heap[Ins[5:1]] -> R[Ins[0]]: SEL_MUX1=2, WR[0]=1.
  - Ins[7:6]=10, BR: taken when Ins[0]=0 or ZeroFlag=1. Taken gives SEL_MUX4=1; not taken gives SEL_MUX4=0.
    - Ins[0]=0 with Ins[5:1]=0 is HALT: SEL_MUX4=1 (PC holds), next state HALT.
  - Ins[7:5]=110, LI: SEL_MUX1=3, WR[0]=1.
  - Ins[7:5]=111, minor op selected by Ins[4:2]:
    - 000 PUSH: Stack_Mode=01.
    - 001 POP: Stack_Mode=10, SEL_MUX1=1, WR[0]=1. Stack data is valid in the same cycle.
    - 010 JR: SEL_MUX4=2.
    - 011 NOP.
    - 1xx ST: WR[1]=1. Heap address is Ins[5:1], range 24..31.
  - RETIRED increments by 1 each RUN cycle not trapped, including the HALT instruction. It wraps modulo 2^CNT_W.
- HALT:
  - Drives SEL_MUX4=1 (Ins[5:1]=0, so PC holds); WR=00, Stack_Mode=00.
  - HALTED=1. RETIRED frozen.
  - RESUME=1: SEL_MUX4 switches to 0 that cycle (PC+1), next state RUN.
  - RESUME in RUN or BOOT is ignored.
- Simultaneous events: reset dominates everything.

Optional Feature:
- Macro: MAP_TRAP_ON_E_EN.
- Defined: on an ALU-class instruction in RUN with E=1:
  - WR[0] forced 0 (result discarded).
  - SEL_MUX4=3 (vector to PC 0).
  - TRAP set to 1; it stays set until reset.
  - RETIRED does not increment.
- Not defined: E is ignored; the result is written normally; TRAP is tied 0.

Test Plan:
- Reset low 3 cycles, release -> BOOT outputs SEL_MUX4=3, SEL_MUX5=1, Stack_Mode=11 for one cycle, then RUN. RETIRED=0, HALTED=0.
- Ins=8'b00_00011_1 in RUN -> OPMode_Main=5'b00011, SEL_MUX1=0, WR=01, SEL_MUX4=0. RETIRED +1 next edge.
- Ins=8'b10_00101_1 with ZeroFlag=0 -> SEL_MUX4=0. With ZeroFlag=1 -> SEL_MUX4=1.
- Ins=8'b111_001_0_1 (POP) -> Stack_Mode=10, SEL_MUX1=1, WR=01. Ins=8'b111_100_1_0 (ST) -> WR=10, Stack_Mode=00.
- Ins=8'h80 -> next state HALT, HALTED=1, SEL_MUX4=1 held for 10 cycles, RETIRED unchanged. RESUME pulse -> SEL_MUX4=0, RUN next cycle.
- With MAP_TRAP_ON_E_EN defined: ALU op with E=1 -> WR=00, SEL_MUX4=3, TRAP=1 persists across later instructions. Without the macro: WR=01, TRAP=0.
